// File: rtl/hack_kbd_ps2.sv
// PS/2 scan code set 2 receiver feeding the Hack keyboard register (key_out/key_ld).
// Optional odd-parity enforcement: define HACK_KBD_PARITY_CHECK_EN.
module hack_kbd_ps2 #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key_out,
  output logic        key_ld,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t      state;
  logic [1:0]  clk_sync, data_sync;
  logic        clk_prev;
  logic        fall, bit_in;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [TW-1:0] to_cnt;
  logic        byte_vld;
  logic [7:0]  byte_q;
  logic        ext, brk;
  logic [7:0]  code;
  logic        parity_ok;

  function automatic logic [7:0] map_norm(input logic [7:0] sc);
    case (sc)
      8'h1C: map_norm = 8'd65;  8'h32: map_norm = 8'd66;  8'h21: map_norm = 8'd67;
      8'h23: map_norm = 8'd68;  8'h24: map_norm = 8'd69;  8'h2B: map_norm = 8'd70;
      8'h34: map_norm = 8'd71;  8'h33: map_norm = 8'd72;  8'h43: map_norm = 8'd73;
      8'h3B: map_norm = 8'd74;  8'h42: map_norm = 8'd75;  8'h4B: map_norm = 8'd76;
      8'h3A: map_norm = 8'd77;  8'h31: map_norm = 8'd78;  8'h44: map_norm = 8'd79;
      8'h4D: map_norm = 8'd80;  8'h15: map_norm = 8'd81;  8'h2D: map_norm = 8'd82;
      8'h1B: map_norm = 8'd83;  8'h2C: map_norm = 8'd84;  8'h3C: map_norm = 8'd85;
      8'h2A: map_norm = 8'd86;  8'h1D: map_norm = 8'd87;  8'h22: map_norm = 8'd88;
      8'h35: map_norm = 8'd89;  8'h1A: map_norm = 8'd90;
      8'h45: map_norm = 8'd48;  8'h16: map_norm = 8'd49;  8'h1E: map_norm = 8'd50;
      8'h26: map_norm = 8'd51;  8'h25: map_norm = 8'd52;  8'h2E: map_norm = 8'd53;
      8'h36: map_norm = 8'd54;  8'h3D: map_norm = 8'd55;  8'h3E: map_norm = 8'd56;
      8'h46: map_norm = 8'd57;
      8'h29: map_norm = 8'd32;  8'h5A: map_norm = 8'd128; 8'h66: map_norm = 8'd129;
      8'h76: map_norm = 8'd140;
      8'h05: map_norm = 8'd141; 8'h06: map_norm = 8'd142; 8'h04: map_norm = 8'd143;
      8'h0C: map_norm = 8'd144; 8'h03: map_norm = 8'd145; 8'h0B: map_norm = 8'd146;
      8'h83: map_norm = 8'd147; 8'h0A: map_norm = 8'd148; 8'h01: map_norm = 8'd149;
      8'h09: map_norm = 8'd150; 8'h78: map_norm = 8'd151; 8'h07: map_norm = 8'd152;
      default: map_norm = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] map_ext(input logic [7:0] sc);
    case (sc)
      8'h6B: map_ext = 8'd130;  8'h75: map_ext = 8'd131;  8'h74: map_ext = 8'd132;
      8'h72: map_ext = 8'd133;  8'h6C: map_ext = 8'd134;  8'h69: map_ext = 8'd135;
      8'h7D: map_ext = 8'd136;  8'h7A: map_ext = 8'd137;  8'h70: map_ext = 8'd138;
      8'h71: map_ext = 8'd139;
      default: map_ext = 8'd0;
    endcase
  endfunction

  // Clearing clk_prev on reset keeps a high idle line from looking like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b00;
      data_sync <= 2'b00;
      clk_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous value, giving a true shift chain.
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = data_sync[1];

`ifdef HACK_KBD_PARITY_CHECK_EN
  logic parity_bit;
  assign parity_ok = ^{shift, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= 8'h00;
      bit_cnt   <= 3'd0;
      to_cnt    <= '0;
      byte_vld  <= 1'b0;
      byte_q    <= 8'h00;
      frame_err <= 1'b0;
`ifdef HACK_KBD_PARITY_CHECK_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TW'(1);

      // An edge in the same cycle as expiry wins: the frame keeps going.
      if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        to_cnt    <= '0;
      end else if (fall) begin
        case (state)
          IDLE: if (!bit_in) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
          DATA: begin
            shift   <= {bit_in, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
`ifdef HACK_KBD_PARITY_CHECK_EN
            parity_bit <= bit_in;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (bit_in && parity_ok) begin
              byte_vld <= 1'b1;
              byte_q   <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign code = ext ? map_ext(byte_q) : map_norm(byte_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      ext     <= 1'b0;
      brk     <= 1'b0;
      key_out <= 16'h0000;
      key_ld  <= 1'b0;
    end else begin
      key_ld <= 1'b0;
      if (byte_vld) begin
        case (byte_q)
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          default: begin
            ext <= 1'b0;
            brk <= 1'b0;
            // Breaks only release the key currently shown; repeats of it stay silent.
            if (code != 8'd0) begin
              if (brk) begin
                if (key_out == {8'h00, code}) begin
                  key_out <= 16'h0000;
                  key_ld  <= 1'b1;
                end
              end else if (key_out != {8'h00, code}) begin
                key_out <= {8'h00, code};
                key_ld  <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hack_kbd_ps2.sv
// Scoreboard bench for hack_kbd_ps2: a table-driven key model queues expected
// key_out loads and frame errors; a monitor pops them as the DUT strobes.
module tb_hack_kbd_ps2;
  localparam int TIMEOUT = 150;
  localparam int HALF    = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk, ps2_data;
  logic [15:0] key_out;
  logic        key_ld, frame_err;

  hack_kbd_ps2 #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_out(key_out), .key_ld(key_ld), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int key_q[$];
  int err_q[$];
  int stop_cyc = 0;

  logic [7:0] letters  [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                                8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                                8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digits   [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] fkeys    [12] = '{8'h05,8'h06,8'h04,8'h0C,8'h03,8'h0B,8'h83,8'h0A,8'h01,8'h09,8'h78,8'h07};
  logic [7:0] extkeys  [10] = '{8'h6B,8'h75,8'h74,8'h72,8'h6C,8'h69,8'h7D,8'h7A,8'h70,8'h71};
  logic [7:0] unmapped [5]  = '{8'h75,8'h12,8'h14,8'h0E,8'h58};

  int norm_map[256];
  int ext_map[256];
  bit m_ext, m_brk;
  int m_key;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void init_maps();
    for (int i = 0; i < 256; i++) begin
      norm_map[i] = 0;
      ext_map[i]  = 0;
    end
    for (int i = 0; i < 26; i++) norm_map[letters[i]] = 65 + i;
    for (int i = 0; i < 10; i++) norm_map[digits[i]]  = 48 + i;
    for (int i = 0; i < 12; i++) norm_map[fkeys[i]]   = 141 + i;
    for (int i = 0; i < 10; i++) ext_map[extkeys[i]]  = 130 + i;
    norm_map[8'h29] = 32;
    norm_map[8'h5A] = 128;
    norm_map[8'h66] = 129;
    norm_map[8'h76] = 140;
  endfunction

  // Reference behaviour for one accepted byte.
  function automatic void model_byte(input logic [7:0] b);
    int v;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      v = m_ext ? ext_map[b] : norm_map[b];
      if (v != 0) begin
        if (m_brk && v == m_key) begin
          m_key = 0;
          key_q.push_back(0);
        end else if (!m_brk && v != m_key) begin
          m_key = v;
          key_q.push_back(v);
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  task automatic send_bit(input logic b, input bit is_stop);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF/2) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF/2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
`ifdef HACK_KBD_PARITY_CHECK_EN
    if (bad_par) err_q.push_back(1);
    else         model_byte(b);
`else
    model_byte(b);
`endif
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(1'b1, 1'b1);
  endtask

  task automatic send_key(input logic [7:0] sc, input bit ext, input bit brk);
    if (ext) send_frame(8'hE0, 1'b0);
    if (brk) send_frame(8'hF0, 1'b0);
    send_frame(sc, 1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT strobes key_ld or frame_err.
  initial begin : monitor
    int prev_key;
    int exp;
    int lat;
    prev_key = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (key_ld) begin
          if (key_q.size() == 0) check("ld_spurious", key_q.size(), 1);
          else begin
            exp = key_q.pop_front();
            lat = cyc - stop_cyc;
            check("key_out", int'(key_out), exp);
            check("key_hi_zero", int'(key_out[15:8]), 0);
            check("ld_latency_ok", int'(lat >= 3 && lat <= 6), 1);
            check("ld_on_change", int'(int'(key_out) != prev_key), 1);
          end
        end else if (int'(key_out) != prev_key) begin
          check("silent_change", int'(key_ld), 1);
        end
        if (frame_err) begin
          check("frame_err_expected", int'(err_q.size() > 0), 1);
          if (err_q.size() > 0) void'(err_q.pop_front());
        end
      end
      prev_key = int'(key_out);
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] held_sc;
    bit held_ext;
    int kind;
    logic [7:0] sc;
    bit e;
    init_maps();
    m_ext = 0; m_brk = 0; m_key = 0;
    held_sc = 8'h00; held_ext = 0;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_key_out", int'(key_out), 0);
    check("rst_key_ld", int'(key_ld), 0);
    check("rst_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Letter press/release; F0 alone must not strobe.
    send_key(8'h1C, 0, 0);
    send_frame(8'hF0, 1'b0);
    repeat (20) @(negedge clk);
    send_frame(8'h1C, 1'b0);
    // Extended key, then the unmapped plain keypad code.
    send_key(8'h75, 1, 0);
    send_key(8'h75, 1, 1);
    send_key(8'h75, 0, 0);
    // Overlapping keys with typematic repeat.
    send_key(8'h1C, 0, 0);
    send_key(8'h32, 0, 0);
    send_key(8'h32, 0, 0);
    send_key(8'h1C, 0, 1);
    send_key(8'h32, 0, 1);
    // Inverted parity on 0x1C.
    send_frame(8'h1C, 1'b1);
    repeat (20) @(negedge clk);
    check("parity_key_out", int'(key_out), m_key);
    send_key(8'h1C, 0, 1);

    // Timeout: start bit plus five data bits, then the line goes quiet.
    err_q.push_back(1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    repeat (TIMEOUT + 40) @(negedge clk);
    check("timeout_err_popped", err_q.size(), 0);
    send_key(8'h29, 0, 0);
    send_key(8'h29, 0, 1);

    // Reset mid-frame while a key is held.
    send_key(8'h1C, 0, 0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_key_out", int'(key_out), 0);
    check("midrst_key_ld", int'(key_ld), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    m_ext = 0; m_brk = 0; m_key = 0;
    rst = 1'b0;
    repeat (TIMEOUT + 20) @(negedge clk);
    send_key(8'h5A, 0, 0);
    held_sc = 8'h5A; held_ext = 0;

    // Randomised key traffic.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      e = 1'b0;
      if (kind < 3) begin
        send_key(held_sc, held_ext, 1'b1);
      end else begin
        case (kind)
          3, 4: sc = letters[$urandom_range(0, 25)];
          5:    sc = digits[$urandom_range(0, 9)];
          6:    sc = fkeys[$urandom_range(0, 11)];
          7:    begin sc = extkeys[$urandom_range(0, 9)]; e = 1'b1; end
          8:    sc = unmapped[$urandom_range(0, 4)];
          default: begin sc = letters[$urandom_range(0, 25)]; e = 1'b1; end
        endcase
        send_key(sc, e, $urandom_range(0, 3) == 0);
        held_sc = sc; held_ext = e;
      end
    end

    repeat (50) @(negedge clk);
    check("final_key_out", int'(key_out), m_key);
    check("key_q_drained", key_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hack_kbd_ps2.md
# hack_kbd_ps2

PS/2 keyboard receiver for the Hack computer, upstream of the memory-mapped keyboard register at address 0x6000. It deserialises PS/2 device-to-host frames and decodes scan code set 2 make, break and extended sequences into Hack key codes. It drives `key_out` and a one-cycle `key_ld` straight into the keyboard register's `in` and `ld` pins. The register then holds the code of the currently pressed key, or 0 when no key is pressed.

## Interface
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles allowed between PS/2 falling edges inside a frame before the frame is abandoned.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock from the device, asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the device, asynchronous.
- `key_out`  out  16  current Hack key code; 0 = no key.
- `key_ld`  out  1  one-cycle strobe; asserted only in the cycle `key_out` takes a new value.
- `frame_err`  out  1  one-cycle strobe on a framing, parity or timeout error.

## Operation
- **Input synchronisers.** `ps2_clk` and `ps2_data` each pass through 2-FF synchronisers. A falling edge is detected when the previous synchronised clock is 1 and the current one is 0. Data is sampled on that edge.
- **Frame state machine, IDLE → DATA → PARITY → STOP → IDLE.**
  - IDLE: a falling edge with data=0 is a start bit and moves to DATA. A falling edge with data=1 is ignored, with no error.
  - DATA: shifts 8 bits, LSB first, using a 3-bit counter. After bit 7 it moves to PARITY.
  - PARITY: captures the parity bit.
  - STOP: data=1 completes the frame. Data=0 pulses `frame_err`, discards the byte and returns to IDLE.
- **Timeout.** In any non-IDLE state, a counter counts cycles since the last falling edge. On reaching `TIMEOUT_CYCLES` the block returns to IDLE and pulses `frame_err`. The counter is cleared on every falling edge and while in IDLE.
- **Decoder flags.** The decoder holds two flags, `ext` and `brk`.
  - Byte 0xE0 sets `ext`.
  - Byte 0xF0 sets `brk`.
  - Any other byte is processed as a key using the current flags, then both flags clear.
- **Key mapping (set 2 → Hack).**
  - Letters map to uppercase ASCII, A-Z → 65-90 (e.g. 0x1C→65, 0x32→66).
  - Digits 0-9 map to 48-57 (0x45,16,1E,26,25,2E,36,3D,3E,46).
  - Space 0x29→32, Enter 0x5A→128, Backspace 0x66→129, Esc 0x76→140.
  - F1-F12 → 141-152 (standard positions).
  - Extended keys: left E0 6B→130, up E0 75→131, right E0 74→132, down E0 72→133, home E0 6C→134, end E0 69→135, pgup E0 7D→136, pgdn E0 7A→137, insert E0 70→138, delete E0 71→139.
  - Any other code is unmapped.
- **Make handling.** A mapped make code whose value differs from `key_out` loads `key_out` and pulses `key_ld`. A typematic repeat of the same code causes no change and no strobe. Unmapped makes are ignored.
- **Break handling.** A mapped break whose code equals `key_out` loads 0 and pulses `key_ld`. A break of any other key is ignored, so the last-pressed key stays held.
- **Width rules.** Hack codes are zero-extended to 16 bits; `key_out[15:8]` is always 0.

## Timing
- **Reset values.** `key_out`=0, `key_ld`=0, `frame_err`=0, state IDLE, `ext`=`brk`=0, shift register, bit counter and timeout counter all 0.
- **Synchroniser latency.** A falling edge on raw `ps2_clk` is detected 3 cycles after it occurs: 2 synchroniser stages plus the edge register.
- **Decode latency.** Let S be the cycle in which the stop-bit edge is detected. The internal byte strobe is at S+1. `key_out` and `key_ld` update at S+2. A `frame_err` for a bad stop bit is asserted at S+1.
- **Reset priority.** `rst` beats all other events. Reset mid-frame abandons the frame silently, with no `frame_err`.
- **Concurrent events.** Timeout and a falling edge in the same cycle: the edge wins and the counter clears. Back-to-back frames need no idle gap beyond the PS/2 stop bit.

## Configuration
- **Macro `HACK_KBD_PARITY_CHECK_EN`.**
  - Defined: at STOP, parity must make the 9 sampled bits odd. On a mismatch the frame pulses `frame_err` at S+1, the byte is discarded and the flags are unchanged.
  - Undefined: the parity bit is sampled and ignored, and every frame with a valid stop bit is accepted.

## Test plan
- **Letter press/release.** Send frame 0x1C → `key_out`=65 with one `key_ld` pulse at S+2. Then send F0,1C → `key_out`=0 with one `key_ld` pulse. 0xF0 alone produces no strobe.
- **Extended key.** Send E0,75 → `key_out`=131. Send E0,F0,75 → `key_out`=0. Then send a plain 0x75 (keypad 8, unmapped) → no change.
- **Overlapping keys.** Send 1C then 32 → `key_out`=66. Send F0,1C → stays 66 with no strobe. Send F0,32 → 0. Repeating 32 while held produces no extra `key_ld`.
- **Parity.** Send 0x1C with inverted parity. With the macro defined → `frame_err` pulse and `key_out` stays 0. Without it → `key_out`=65.
- **Timeout.** Send start bit plus 5 data bits, then hold `ps2_clk` high for `TIMEOUT_CYCLES` cycles → one `frame_err` pulse and return to IDLE. A following valid 0x29 → `key_out`=32.
- **Reset mid-frame.** Assert `rst` after 4 data bits → all outputs 0 with no `frame_err`. A following valid 0x5A → `key_out`=128.
